gb_stencil_window_gen: RTL

- Parametrised streaming KxK stencil-window generator for the Gaussian-blur accelerator datapath; successor to the fixed 9x9, 8-bit, hard-coded-resolution stencil model.
- Accepts one pixel per handshake on the arg_1 AXI-stream input in raster order, buffering KSIZE-1 image lines.
- Emits complete KxK windows on the arg_0 AXI-stream output, with frame markers and full backpressure; feeds the downstream blur-kernel function.

---
 rtl/gb_stencil_window_gen_pkg.sv | 21 ++
 rtl/gb_stencil_window_gen_line_buffer.sv | 28 ++
 rtl/gb_stencil_window_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gb_stencil_window_gen_pkg.sv
// Shared defaults, derived widths and window-element indexing for the stencil window generator.
package gb_stencil_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int KSIZE_DEF = 9;
  localparam int IMG_W_DEF = 648;
  localparam int IMG_H_DEF = 488;
  localparam int FCNT_W_DEF = 16;

  localparam int X_W   = $clog2(IMG_W_DEF);
  localparam int Y_W   = $clog2(IMG_H_DEF);
  localparam int WIN_W = PIX_W_DEF * KSIZE_DEF * KSIZE_DEF;

  // Bit offset of window element (r,c); r=0 is the oldest line, c=0 the oldest column.
  function automatic int win_idx(input int r, input int c,
                                 input int ksize = KSIZE_DEF,
                                 input int pix_w = PIX_W_DEF);
    return (r * ksize + c) * pix_w;
  endfunction

endpackage

// File: rtl/gb_stencil_window_gen_line_buffer.sv
// KSIZE-1 image lines stored as one wide word per column; a write shifts the column up one line.
// Read is combinational so the accept cycle sees the pre-write contents (read-before-write).
module gb_line_buffer #(
  parameter int IMG_W = 648,
  parameter int PIX_W = 8,
  parameter int KSIZE = 9
) (
  input  logic                        clk,
  input  logic                        wr_en_i,
  input  logic [$clog2(IMG_W)-1:0]    addr_i,
  input  logic [PIX_W-1:0]            pix_i,
  output logic [PIX_W*(KSIZE-1)-1:0]  rd_dat_o
);

  localparam int LB_W = PIX_W * (KSIZE - 1);

  logic [LB_W-1:0] mem_q [IMG_W];

  assign rd_dat_o = mem_q[addr_i];

  // Slot r takes slot r+1; the newest pixel lands in the top slot (r = KSIZE-2).
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= {pix_i, rd_dat_o[LB_W-1:PIX_W]};
    end
  end

endmodule

// File: rtl/gb_stencil_window_gen.sv
// Streaming KxK window generator: raster pixels in, one complete window out per emitting pixel.
// One cycle from accepting a pixel to its window on arg_0; input stalls while the output is held.
module gb_stencil_window_gen
  import gb_stencil_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int KSIZE  = KSIZE_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int FCNT_W = FCNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PIX_W-1:0]               arg_1_TDATA,
  input  logic                           arg_1_TVALID,
  output logic                           arg_1_TREADY,
  output logic [PIX_W*KSIZE*KSIZE-1:0]   arg_0_TDATA,
  output logic                           arg_0_TVALID,
  input  logic                           arg_0_TREADY,
  output logic                           arg_0_TUSER,
  output logic                           arg_0_TLAST,
  output logic [$clog2(IMG_W)-1:0]       pos_x,
  output logic [$clog2(IMG_H)-1:0]       pos_y,
  output logic [FCNT_W-1:0]              frame_cnt
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int WW   = PIX_W * KSIZE * KSIZE;
  localparam int LB_W = PIX_W * (KSIZE - 1);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_GATE = XW'(KSIZE - 1);
  localparam logic [YW-1:0] Y_GATE = YW'(KSIZE - 1);

  logic              rst_q;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [WW-1:0]     win_q, win_d;
  logic              vld_q, vld_d;
  logic              user_q, user_d;
  logic              last_q, last_d;
  logic [LB_W-1:0]   lb_rd;
  logic              accept;
  logic              emit;

  assign arg_1_TREADY = !rst_q && (!vld_q || arg_0_TREADY);
  assign accept       = arg_1_TVALID && arg_1_TREADY;
  assign emit         = (x_q >= X_GATE) && (y_q >= Y_GATE);

  gb_line_buffer #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W),
    .KSIZE (KSIZE)
  ) u_line_buffer (
    .clk      (clk),
    .wr_en_i  (accept),
    .addr_i   (x_q),
    .pix_i    (arg_1_TDATA),
    .rd_dat_o (lb_rd)
  );

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    fcnt_d = fcnt_q;
    win_d  = win_q;
    vld_d  = vld_q;
    user_d = user_q;
    last_d = last_q;

    if (accept) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) begin
          win_d[win_idx(r, c, KSIZE, PIX_W) +: PIX_W] = win_q[win_idx(r, c + 1, KSIZE, PIX_W) +: PIX_W];
        end
      end
      for (int r = 0; r < KSIZE - 1; r++) begin
        win_d[win_idx(r, KSIZE - 1, KSIZE, PIX_W) +: PIX_W] = lb_rd[r * PIX_W +: PIX_W];
      end
      win_d[win_idx(KSIZE - 1, KSIZE - 1, KSIZE, PIX_W) +: PIX_W] = arg_1_TDATA;

      vld_d  = emit;
      user_d = emit && (x_q == X_GATE) && (y_q == Y_GATE);
      last_d = emit && (x_q == X_LAST) && (y_q == Y_LAST);

      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d    = '0;
          fcnt_d = fcnt_q + FCNT_W'(1);
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end else if (arg_0_TREADY) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q  <= 1'b1;
      x_q    <= '0;
      y_q    <= '0;
      fcnt_q <= '0;
      win_q  <= '0;
      vld_q  <= 1'b0;
      user_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      rst_q  <= 1'b0;
      x_q    <= x_d;
      y_q    <= y_d;
      fcnt_q <= fcnt_d;
      win_q  <= win_d;
      vld_q  <= vld_d;
      user_q <= user_d;
      last_q <= last_d;
    end
  end

  // The window register doubles as the output register; it only moves on accept, so it holds under stall.
  assign arg_0_TDATA  = win_q;
  assign arg_0_TVALID = vld_q;
  assign arg_0_TUSER  = user_q;
  assign arg_0_TLAST  = last_q;
  assign pos_x        = x_q;
  assign pos_y        = y_q;
  assign frame_cnt    = fcnt_q;

endmodule
